// File: rtl/blake2_msg_scheduler.sv
// BLAKE2b message scheduler: packs host words into FIFO blocks, zero-pads the
// last block and issues init/next commands with the running byte counter.
module blake2_msg_scheduler #(
  parameter int DBITS       = 64,
  parameter int BLOCK_WORDS = 16,
  parameter int CTR_W       = 128,
  parameter int BYTES_W     = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DBITS-1:0]   s_data,
  input  logic               s_last,
  input  logic [BYTES_W-1:0] s_bytes,
  output logic               fifo_wr,
  output logic [DBITS-1:0]   fifo_din,
  output logic               fifo_rd,
  input  logic               fifo_full,
  output logic               core_init,
  output logic               core_next,
  output logic               core_final,
  output logic [CTR_W-1:0]   core_t,
  input  logic               core_ready,
  output logic               busy,
  output logic               done
);

  localparam int WCNT_W = $clog2(BLOCK_WORDS + 1);
  localparam logic [WCNT_W-1:0] LAST_IDX   = WCNT_W'(BLOCK_WORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE   = WCNT_W'(1);
  localparam logic [CTR_W-1:0]  WORD_BYTES = CTR_W'(DBITS / 8);

  typedef enum logic [2:0] {IDLE, INIT, FILL, PAD, POP, LOAD, WAIT, FIN} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CTR_W-1:0]  t_q, t_d;
  logic [CTR_W-1:0]  core_t_q, core_t_d;
  logic              last_q, last_d;
  logic              final_q, final_d;
  logic              settle_q, settle_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      t_q      <= '0;
      core_t_q <= '0;
      last_q   <= 1'b0;
      final_q  <= 1'b0;
      settle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      t_q      <= t_d;
      core_t_q <= core_t_d;
      last_q   <= last_d;
      final_q  <= final_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    t_d       = t_q;
    core_t_d  = core_t_q;
    last_d    = last_q;
    final_d   = final_q;
    settle_d  = settle_q;
    s_ready   = 1'b0;
    fifo_wr   = 1'b0;
    fifo_din  = '0;
    fifo_rd   = 1'b0;
    core_init = 1'b0;
    core_next = 1'b0;
    done      = 1'b0;
    busy      = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          t_d      = '0;
          core_t_d = '0;
          final_d  = 1'b0;
          wcnt_d   = '0;
          last_d   = 1'b0;
          state_d  = INIT;
        end
      end
      INIT: begin
        if (core_ready) begin
          core_init = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        s_ready = !fifo_full;
        if (s_valid && !fifo_full) begin
          fifo_wr  = 1'b1;
          fifo_din = s_data;
          wcnt_d   = wcnt_q + WCNT_ONE;
          // Tail bytes of the last word are forwarded untouched; only t reflects them.
          t_d      = t_q + (s_last ? CTR_W'(s_bytes) : WORD_BYTES);
          if (s_last) last_d = 1'b1;
          if (wcnt_q == LAST_IDX) state_d = POP;
          else if (s_last)        state_d = PAD;
        end
      end
      PAD: begin
        if (!fifo_full) begin
          fifo_wr = 1'b1;
          wcnt_d  = wcnt_q + WCNT_ONE;
          if (wcnt_q == LAST_IDX) state_d = POP;
        end
      end
      POP: begin
        fifo_rd = 1'b1;
        wcnt_d  = '0;
        state_d = LOAD;
      end
      LOAD: begin
        if (core_ready) begin
          core_next = 1'b1;
          core_t_d  = t_q;
          final_d   = last_q;
          settle_d  = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        // The first WAIT cycle gives the core time to drop core_ready.
        if (settle_q)        settle_d = 1'b0;
        else if (core_ready) state_d  = last_q ? FIN : FILL;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // In LOAD the live values are presented; afterwards the issued values are held.
  assign core_t     = (state_q == LOAD) ? t_q : core_t_q;
  assign core_final = (state_q == LOAD) ? last_q : final_q;

endmodule
